// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: owns the single write port (A3/WD3/WE3) of the 32x32
// register file. After reset it writes zero to every register, because the
// register file itself has no reset. It then shares the write port between
// NREQ writeback requesters using round-robin valid/ready arbitration.
//
// Optional feature: define REGFILE_ARB_SCOREBOARD_EN to add a pending-write
// scoreboard (BUSY) that the decode stage uses for hazard checks.
//
// Ports:
//   CLK, RESETn          clock; asynchronous active-low reset
//   REQ_VALID/REQ_READY  per-requester handshake (READY is combinational, one-hot or zero)
//   REQ_ADDR, REQ_DATA   per-requester destination register and write data
//   A3, WD3, WE3         register-file write port
//   INIT_DONE            registered; high once the clear sequence has finished
//   ISSUE_VALID/ISSUE_RD decode marks a destination register as pending
//   ISSUE_READY          issue accepted this cycle
//   BUSY                 pending-write bit per register
module regfile_wb_arbiter #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  input  logic [NREQ-1:0]      REQ_VALID,
  output logic [NREQ-1:0]      REQ_READY,
  input  logic [NREQ*5-1:0]    REQ_ADDR,
  input  logic [NREQ*XLEN-1:0] REQ_DATA,
  output logic [4:0]           A3,
  output logic [XLEN-1:0]      WD3,
  output logic                 WE3,
  output logic                 INIT_DONE,
  input  logic                 ISSUE_VALID,
  input  logic [4:0]           ISSUE_RD,
  output logic                 ISSUE_READY,
  output logic [NREGS-1:0]     BUSY
);

  localparam int unsigned AW = 5;
  localparam int unsigned PW = (NREQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {S_RST, S_CLEAR, S_RUN} state_t;

  state_t          state, state_next;
  logic [AW-1:0]   clr_cnt;
  logic [PW-1:0]   ptr;
  logic            init_done;
  logic [PW-1:0]   cand;
  logic            gnt_found;
  logic [PW-1:0]   gnt_idx;
  logic [AW-1:0]   sel_addr;
  logic [XLEN-1:0] sel_data;
  logic            hs;
  logic            issue_ok;

  // State register
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state <= S_RST;
    else         state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_RST:   state_next = S_CLEAR;
      S_CLEAR: if (clr_cnt == AW'(NREGS - 1)) state_next = S_RUN;
      S_RUN:   state_next = S_RUN;
      default: state_next = S_RST;
    endcase
  end

  // Round-robin search starting at ptr, wrapping modulo NREQ
  always_comb begin
    cand      = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((32'(ptr) + 32'(k)) % NREQ);
      if (!gnt_found && REQ_VALID[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Route the granted requester's address and data
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_found && (gnt_idx == PW'(i))) begin
        sel_addr = REQ_ADDR[i*AW +: AW];
        sel_data = REQ_DATA[i*XLEN +: XLEN];
      end
    end
  end

  assign hs = (state == S_RUN) && gnt_found;

  // Output logic; the write lands at the same edge as the grant
  always_comb begin
    REQ_READY   = '0;
    A3          = '0;
    WD3         = '0;
    WE3         = 1'b0;
    ISSUE_READY = issue_ok;
    case (state)
      S_CLEAR: begin
        WE3 = 1'b1;
        A3  = clr_cnt;
      end
      S_RUN: begin
        if (gnt_found) begin
          REQ_READY[gnt_idx] = 1'b1;
          A3  = sel_addr;
          WD3 = sel_data;
          // x0 is hard-wired zero: complete the handshake but suppress the write
          WE3 = (sel_addr != '0);
        end
      end
      default: ;
    endcase
  end

  assign INIT_DONE = init_done;

  // Clear counter, round-robin pointer and init flag
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      clr_cnt   <= '0;
      ptr       <= '0;
      init_done <= 1'b0;
    end else begin
      clr_cnt   <= (state == S_CLEAR) ? clr_cnt + AW'(1) : '0;
      init_done <= (state_next == S_RUN);
      if (hs) ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end

`ifdef REGFILE_ARB_SCOREBOARD_EN
  logic [NREGS-1:0] busy_q, busy_d;

  assign issue_ok = (state == S_RUN) && !busy_q[ISSUE_RD];

  // Write clears, issue sets; a same-cycle set wins over a stale write's clear
  always_comb begin
    busy_d = busy_q;
    if (hs && (sel_addr != '0)) busy_d[sel_addr] = 1'b0;
    if (ISSUE_VALID && issue_ok && (ISSUE_RD != '0)) busy_d[ISSUE_RD] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign BUSY = busy_q;
`else
  logic unused_issue;

  assign issue_ok     = (state == S_RUN);
  assign BUSY         = '0;
  assign unused_issue = ^{ISSUE_VALID, ISSUE_RD};
`endif

endmodule
